// File: rtl/alu_seq_div_pkg.sv
// Shared opcode encodings and FSM state type for the sequential divide ALU.
package alu_pkg;

    localparam logic [1:0] OP_PASS_A = 2'b00;
    localparam logic [1:0] OP_PASS_B = 2'b01;
    localparam logic [1:0] OP_DIV    = 2'b10;
    localparam logic [1:0] OP_MOD    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_seq_div_if.sv
// Operand/opcode request bus and result bus between the source and the ALU.
interface alu_seq_div_if #(
    parameter int WIDTH = 4
);

    // start is taken only while busy is low; the operation is accepted on that
    // edge, and done pulses for one cycle when result/div_by_zero are valid.
    logic             start;
    logic [1:0]       opcode;
    logic [WIDTH-1:0] inputA;
    logic [WIDTH-1:0] inputB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;

    modport master (
        output start,
        output opcode,
        output inputA,
        output inputB,
        input  busy,
        input  done,
        input  result,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  opcode,
        input  inputA,
        input  inputB,
        output busy,
        output done,
        output result,
        output div_by_zero
    );

endinterface

// File: rtl/alu_seq_div_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0] w_shift;
    logic           w_ge;

    always_comb begin
        // Partial remainder stays below B, so one extra bit covers the shift.
        w_shift = {i_rem, i_q[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, i_b});
        o_rem   = w_ge ? (w_shift[WIDTH-1:0] - i_b) : w_shift[WIDTH-1:0];
        o_q     = {i_q[WIDTH-2:0], w_ge};
    end

endmodule

// File: rtl/alu_seq_div.sv
// Sequential ALU: pass A, pass B, and quotient/remainder from an iterative
// restoring divider that retires one quotient bit per clock.
module alu_seq_div
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_seq_div_if.slave bus,
    output state_t       o_state
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_dbz;

    logic             w_accept;
    logic             w_direct;
    logic             w_is_div_op;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_direct_result;
    logic             w_last_step;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem (r_rem),
        .i_q   (r_q),
        .i_b   (r_b),
        .o_rem (w_rem_nxt),
        .o_q   (w_q_nxt)
    );

    always_comb begin
        w_accept    = (r_state == IDLE) && bus.start;
        w_is_div_op = bus.opcode[1];
        w_b_zero    = (bus.inputB == '0);
        // Pass ops and a zero divisor never iterate.
        w_direct    = !w_is_div_op || w_b_zero;
        w_last_step = (r_state == RUN) && (r_cnt == CW'(1));

        w_direct_result = bus.inputA;
        case (bus.opcode)
            OP_PASS_A: w_direct_result = bus.inputA;
            OP_PASS_B: w_direct_result = bus.inputB;
            OP_DIV:    w_direct_result = '1;
            OP_MOD:    w_direct_result = bus.inputA;
            default:   w_direct_result = bus.inputA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_direct ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last_step) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_PASS_A;
            r_b      <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= bus.opcode;
                r_b  <= bus.inputB;
                if (w_direct) begin
                    r_result <= w_direct_result;
                    r_dbz    <= w_is_div_op && w_b_zero;
                end else begin
                    r_rem <= '0;
                    r_q   <= bus.inputA;
                    r_cnt <= CW'(WIDTH);
                end
            end else if (r_state == RUN) begin
                r_rem <= w_rem_nxt;
                r_q   <= w_q_nxt;
                r_cnt <= r_cnt - CW'(1);
                if (w_last_step) begin
                    r_result <= (r_op == OP_DIV) ? w_q_nxt : w_rem_nxt;
                    r_dbz    <= 1'b0;
                end
            end
        end
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = (r_state == DONE);
    assign bus.result      = r_result;
    assign bus.div_by_zero = r_dbz;
    assign o_state         = r_state;

endmodule

// File: tb/tb_alu_seq_div.sv
// Bench for alu_seq_div at WIDTH=4 and WIDTH=8: directed vectors feed a
// scoreboard of expected result, div_by_zero flag and done cycle.
module tb_alu_seq_div;
    import alu_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t st4;
    state_t st8;

    always #5 clk = ~clk;

    alu_seq_div_if #(.WIDTH(4)) bus4 ();
    alu_seq_div_if #(.WIDTH(8)) bus8 ();

    alu_seq_div #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus4),
        .o_state (st4)
    );

    alu_seq_div #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus8),
        .o_state (st8)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Entry layout: {done cycle[40:9], div_by_zero[8], result[7:0]}
    logic [40:0] exp4_q[$];
    logic [40:0] exp8_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [40:0] e;
        if (!rst && bus4.done) begin
            if (exp4_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w4_unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                e = exp4_q.pop_front();
                check("w4_result", 32'(bus4.result), 32'(e[7:0]));
                check("w4_div_by_zero", 32'(bus4.div_by_zero), 32'(e[8]));
                check("w4_done_cycle", cyc, e[40:9]);
            end
        end
        if (!rst && bus8.done) begin
            if (exp8_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w8_unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                e = exp8_q.pop_front();
                check("w8_result", 32'(bus8.result), 32'(e[7:0]));
                check("w8_div_by_zero", 32'(bus8.div_by_zero), 32'(e[8]));
                check("w8_done_cycle", cyc, e[40:9]);
            end
        end
    end

    // lat = number of edges from the accept edge (inclusive) until done is visible.
    task automatic issue(input int sel, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] r, input logic dz,
                         input int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (((sel == 4) ? bus4.busy : bus8.busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy expected=idle (width %0d)", sel);
            return;
        end
        if (sel == 4) begin
            bus4.opcode = op;
            bus4.inputA = a[3:0];
            bus4.inputB = b[3:0];
            bus4.start  = 1'b1;
            exp4_q.push_back({32'(cyc + lat), dz, r});
        end else begin
            bus8.opcode = op;
            bus8.inputA = a;
            bus8.inputB = b;
            bus8.start  = 1'b1;
            exp8_q.push_back({32'(cyc + lat), dz, r});
        end
        @(posedge clk);
        #1;
        if (sel == 4) begin
            bus4.start = 1'b0;
            check("w4_busy_after_accept", 32'(bus4.busy), 32'd1);
        end else begin
            bus8.start = 1'b0;
            check("w8_busy_after_accept", 32'(bus8.busy), 32'd1);
        end
    endtask

    initial begin
        int n;
        bus4.start = 1'b0; bus4.opcode = 2'b00; bus4.inputA = '0; bus4.inputB = '0;
        bus8.start = 1'b0; bus8.opcode = 2'b00; bus8.inputA = '0; bus8.inputB = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_busy", 32'(bus4.busy), 32'd0);
        check("reset_done", 32'(bus4.done), 32'd0);
        check("reset_result", 32'(bus4.result), 32'd0);
        check("reset_div_by_zero", 32'(bus4.div_by_zero), 32'd0);
        check("reset_state", 32'(st4), 32'(IDLE));
        check("reset_result_w8", 32'(bus8.result), 32'd0);

        // WIDTH=4 directed vectors
        issue(4, 2'b10, 8'd13, 8'd4, 8'd3,  1'b0, 5);
        issue(4, 2'b11, 8'd13, 8'd4, 8'd1,  1'b0, 5);
        issue(4, 2'b10, 8'd9,  8'd0, 8'd15, 1'b1, 1);
        issue(4, 2'b11, 8'd9,  8'd0, 8'd9,  1'b1, 1);
        issue(4, 2'b00, 8'd6,  8'd2, 8'd6,  1'b0, 1);
        issue(4, 2'b01, 8'd6,  8'd2, 8'd2,  1'b0, 1);
        issue(4, 2'b10, 8'd0,  8'd3, 8'd0,  1'b0, 5);
        issue(4, 2'b10, 8'd11, 8'd1, 8'd11, 1'b0, 5);
        issue(4, 2'b11, 8'd3,  8'd7, 8'd3,  1'b0, 5);
        issue(4, 2'b11, 8'd15, 8'd9, 8'd6,  1'b0, 5);

        // Inputs and a start pulse during busy must not disturb 15/2.
        issue(4, 2'b10, 8'd15, 8'd2, 8'd7, 1'b0, 5);
        @(negedge clk);
        bus4.inputA = 4'd1;
        bus4.inputB = 4'd1;
        bus4.start  = 1'b1;
        @(negedge clk);
        bus4.start  = 1'b0;

        // Abort a division with reset in its second cycle.
        n = 0;
        while ((bus4.busy || exp4_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("pre_abort_idle", 32'(bus4.busy), 32'd0);
        bus4.opcode = 2'b10;
        bus4.inputA = 4'd13;
        bus4.inputB = 4'd4;
        bus4.start  = 1'b1;
        @(posedge clk);
        #1 bus4.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus4.busy), 32'd0);
        check("abort_done", 32'(bus4.done), 32'd0);
        check("abort_result", 32'(bus4.result), 32'd0);
        check("abort_div_by_zero", 32'(bus4.div_by_zero), 32'd0);
        check("abort_state", 32'(st4), 32'(IDLE));
        repeat (8) @(negedge clk);
        issue(4, 2'b11, 8'd12, 8'd5, 8'd2, 1'b0, 5);

        // WIDTH=8 directed vectors
        issue(8, 2'b10, 8'd200, 8'd7,   8'd28,  1'b0, 9);
        issue(8, 2'b11, 8'd200, 8'd7,   8'd4,   1'b0, 9);
        issue(8, 2'b10, 8'd255, 8'd1,   8'd255, 1'b0, 9);
        issue(8, 2'b11, 8'd255, 8'd1,   8'd0,   1'b0, 9);
        issue(8, 2'b10, 8'd5,   8'd9,   8'd0,   1'b0, 9);
        issue(8, 2'b11, 8'd5,   8'd9,   8'd5,   1'b0, 9);
        issue(8, 2'b11, 8'd255, 8'd16,  8'd15,  1'b0, 9);
        issue(8, 2'b10, 8'd255, 8'd255, 8'd1,   1'b0, 9);
        issue(8, 2'b11, 8'd255, 8'd254, 8'd1,   1'b0, 9);
        issue(8, 2'b10, 8'd129, 8'd128, 8'd1,   1'b0, 9);
        issue(8, 2'b11, 8'd100, 8'd0,   8'd100, 1'b1, 1);
        issue(8, 2'b10, 8'd0,   8'd3,   8'd0,   1'b0, 9);

        n = 0;
        while ((exp4_q.size() != 0 || exp8_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        check("w4_queue_drained", 32'(exp4_q.size()), 32'd0);
        check("w8_queue_drained", 32'(exp8_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
